spi_master_arbiter: RTL and testbench

// - Shares one transmitter_SPI master between N_REQ requesters using round-robin arbitration.
// - Latches the winner's byte and SPI mode, then drives the master's strt/data_in/CKP/CPH.
// - Tracks the transaction through the master's CS line and returns a done pulse to the winner.
// - Sits between client logic and the SPI master; the master's MOSI/MISO/SCK path is untouched.

---
 rtl/spi_master_arbiter.sv | 132 +++++++++++++
 tb/tb_spi_master_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin sharing of one transmitter_SPI master between N_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to add the LAUNCH/ACTIVE watchdog and the ERR state.
module spi_master_arbiter #(
    parameter int N_REQ = 4
`ifdef SPI_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [2*N_REQ-1:0] req_mode,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [N_REQ-1:0]   err,
    output logic               busy,
    output logic               spi_strt,
    output logic [7:0]         spi_data_in,
    output logic               spi_CKP,
    output logic               spi_CPH,
    input  logic               spi_CS
);
    localparam int PW = $clog2(N_REQ);
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_ACTIVE, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_ACTIVE, S_DONE} state_t;
`endif
    state_t state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
    logic [PW-1:0] rr_q, rr_d, sel;
    logic [7:0] data_q, data_d;
    logic strt_q, strt_d, ckp_q, ckp_d, cph_q, cph_d;
`ifdef SPI_ARB_TIMEOUT_EN
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] err_q, err_d;
    logic tmo;
    assign tmo = cnt_q == CW'(TIMEOUT_CYCLES - 1);
`endif
    // rr_q doubles as the current winner: lowest request above it wins, else lowest overall
    always_comb begin
        sel = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) sel = PW'(i);
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i] && PW'(i) > rr_q) sel = PW'(i);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= PW'(N_REQ - 1);
            gnt_q   <= '0;
            done_q  <= '0;
            data_q  <= '0;
            strt_q  <= 1'b0;
            ckp_q   <= 1'b0;
            cph_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            data_q  <= data_d;
            strt_q  <= strt_d;
            ckp_q   <= ckp_d;
            cph_q   <= cph_d;
        end
    end
`ifdef SPI_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = |req ? S_LAUNCH : S_IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
            S_LAUNCH: state_d = !spi_CS ? S_ACTIVE : tmo ? S_ERR : S_LAUNCH;
            S_ACTIVE: state_d = spi_CS ? S_DONE : tmo ? S_ERR : S_ACTIVE;
`else
            S_LAUNCH: state_d = !spi_CS ? S_ACTIVE : S_LAUNCH;
            S_ACTIVE: state_d = spi_CS ? S_DONE : S_ACTIVE;
`endif
            default:  state_d = S_IDLE;
        endcase
    end
    always_comb begin
        gnt_d  = gnt_q;
        rr_d   = rr_q;
        data_d = data_q;
        ckp_d  = ckp_q;
        cph_d  = cph_q;
        if (state_q == S_IDLE && |req) begin
            gnt_d  = N_REQ'(1) << sel;
            rr_d   = sel;
            data_d = req_data[{sel, 3'b000} +: 8];
            {ckp_d, cph_d} = req_mode[{sel, 1'b0} +: 2];
        end
        if (state_q == S_DONE) gnt_d = '0;
        // strt waits one LAUNCH cycle so it rises the cycle after the grant
        strt_d = state_q == S_LAUNCH && state_d == S_LAUNCH;
        done_d = state_d == S_DONE ? N_REQ'(1) << rr_q : '0;
`ifdef SPI_ARB_TIMEOUT_EN
        if (state_d == S_ERR) gnt_d = '0;
        err_d = state_d == S_ERR ? N_REQ'(1) << rr_q : '0;
        cnt_d = (state_d == state_q && (state_q == S_LAUNCH || state_q == S_ACTIVE)) ? cnt_q + CW'(1) : '0;
`endif
    end
    assign gnt         = gnt_q;
    assign done        = done_q;
`ifdef SPI_ARB_TIMEOUT_EN
    assign err         = err_q;
`else
    assign err         = '0;
`endif
    assign busy        = state_q != S_IDLE;
    assign spi_strt    = strt_q;
    assign spi_data_in = data_q;
    assign spi_CKP     = ckp_q;
    assign spi_CPH     = cph_q;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: directed self-checking bench for spi_master_arbiter (N_REQ=4).
module tb_spi_master_arbiter;
    logic        clk, rst, busy, spi_strt, spi_CKP, spi_CPH, spi_cs;
    logic [3:0]  req, gnt, done, err;
    logic [31:0] req_data;
    logic [7:0]  req_mode, spi_data_in;
    int checks = 0;
    int errors = 0;

    spi_master_arbiter #(
        .N_REQ(4)
`ifdef SPI_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_mode(req_mode),
        .gnt(gnt), .done(done), .err(err), .busy(busy), .spi_strt(spi_strt),
        .spi_data_in(spi_data_in), .spi_CKP(spi_CKP), .spi_CPH(spi_CPH), .spi_CS(spi_cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        spi_cs = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Plays the master from the grant cycle: waits for strt, runs CS low, ends in the DONE cycle
    task automatic spi_cycle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (spi_strt) ok = 1'b1;
            else tick();
        end
        spi_cs = 1'b0;
        tick();
        tick();
        spi_cs = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b1;
        req = 4'b1111;
        spi_cs = 1'b1;
        tick();
        tick();
        checks++;
        if ({gnt, done, err, busy, spi_strt, spi_data_in, spi_CKP, spi_CPH} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b done=%b err=%b busy=%b strt=%b data=%h ckp=%b cph=%b want all 0",
                     gnt, done, err, busy, spi_strt, spi_data_in, spi_CKP, spi_CPH);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt got %b want 0001", gnt); end
        req = '0;
        spi_cycle(ok);
        tick();
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        req = 4'b0100;
        req_data[23:16] = 8'hA5;
        req_mode[5:4] = 2'b10;
        tick();
        checks++;
        if ({gnt, spi_data_in, spi_CKP, spi_CPH, spi_strt, busy} !== {4'b0100, 8'hA5, 2'b10, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL single_grant got gnt=%b data=%h ckp=%b cph=%b strt=%b busy=%b want 0100 a5 1 0 0 1",
                     gnt, spi_data_in, spi_CKP, spi_CPH, spi_strt, busy);
        end
        tick();
        checks++;
        if (spi_strt !== 1'b1) begin errors++; $display("FAIL single_strt_rise got %b want 1", spi_strt); end
        tick();
        checks++;
        if (spi_strt !== 1'b1) begin errors++; $display("FAIL single_strt_hold got %b want 1", spi_strt); end
        spi_cs = 1'b0;
        tick();
        checks++;
        if ({spi_strt, busy, done} !== {1'b0, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL single_active got strt=%b busy=%b done=%b want 0 1 0000", spi_strt, busy, done);
        end
        tick();
        spi_cs = 1'b1;
        tick();
        checks++;
        if ({done, gnt} !== {4'b0100, 4'b0100}) begin
            errors++;
            $display("FAIL single_done got done=%b gnt=%b want 0100 0100", done, gnt);
        end
        req = '0;
        tick();
        checks++;
        if ({done, gnt, busy} !== 9'd0) begin
            errors++;
            $display("FAIL single_after got done=%b gnt=%b busy=%b want 0", done, gnt, busy);
        end
        ok = ok;
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [3:0] w;
        do_reset();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req_mode = {2'b11, 2'b10, 2'b01, 2'b00};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            w = 4'b0001 << (k % 4);
            tick();
            checks++;
            if ({gnt, spi_data_in, spi_CKP, spi_CPH} !== {w, 8'((k % 4 + 1) * 17), 2'(k % 4)}) begin
                errors++;
                $display("FAIL rr_grant_%0d got gnt=%b data=%h mode=%b%b want %b %h %b",
                         k, gnt, spi_data_in, spi_CKP, spi_CPH, w, 8'((k % 4 + 1) * 17), 2'(k % 4));
            end
            spi_cycle(ok);
            checks++;
            if (!ok || done !== w) begin
                errors++;
                $display("FAIL rr_done_%0d got done=%b strt_seen=%0d want %b 1", k, done, ok, w);
            end
            tick();
            checks++;
            if ({gnt, busy} !== 5'd0) begin
                errors++;
                $display("FAIL rr_idle_gap_%0d got gnt=%b busy=%b want 0000 0", k, gnt, busy);
            end
        end
        req = '0;
    endtask

    task automatic test_latched_data();
        bit ok;
        do_reset();
        req_data[7:0] = 8'h3C;
        req_mode[1:0] = 2'b00;
        req = 4'b0001;
        tick();
        tick();
        spi_cs = 1'b0;
        tick();
        req_data[7:0] = 8'hFF;
        req_mode[1:0] = 2'b11;
        req = 4'b1111;
        tick();
        checks++;
        if ({gnt, spi_data_in, spi_CKP, spi_CPH} !== {4'b0001, 8'h3C, 2'b00}) begin
            errors++;
            $display("FAIL latched_data got gnt=%b data=%h ckp=%b cph=%b want 0001 3c 0 0",
                     gnt, spi_data_in, spi_CKP, spi_CPH);
        end
        req = 4'b0001;
        spi_cs = 1'b1;
        tick();
        checks++;
        if (done !== 4'b0001) begin errors++; $display("FAIL latched_done got %b want 0001", done); end
        req = '0;
        tick();
        ok = ok;
    endtask

    task automatic test_early_drop();
        do_reset();
        req = 4'b0010;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL drop_grant got %b want 0010", gnt); end
        tick();
        spi_cs = 1'b0;
        tick();
        req = '0;
        tick();
        spi_cs = 1'b1;
        tick();
        checks++;
        if (done !== 4'b0010) begin errors++; $display("FAIL drop_done got %b want 0010", done); end
        tick();
        tick();
        checks++;
        if ({done, gnt, busy} !== 9'd0) begin
            errors++;
            $display("FAIL drop_after got done=%b gnt=%b busy=%b want 0", done, gnt, busy);
        end
    endtask

    task automatic test_reset_active();
        do_reset();
        req = 4'b1000;
        tick();
        tick();
        spi_cs = 1'b0;
        tick();
        checks++;
        if ({busy, gnt} !== {1'b1, 4'b1000}) begin
            errors++;
            $display("FAIL rstact_pre got busy=%b gnt=%b want 1 1000", busy, gnt);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({gnt, done, busy, spi_strt} !== 10'd0) begin
            errors++;
            $display("FAIL rstact_abort got gnt=%b done=%b busy=%b strt=%b want 0", gnt, done, busy, spi_strt);
        end
        rst = 1'b0;
        req = '0;
        spi_cs = 1'b1;
        tick();
        checks++;
        if ({done, err, busy} !== 9'd0) begin
            errors++;
            $display("FAIL rstact_nodone got done=%b err=%b busy=%b want 0", done, err, busy);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0001;
        spi_cs = 1'b1;
        tick();
`ifdef SPI_ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if ({err, busy, spi_strt} !== {4'b0000, 2'b11}) begin
            errors++;
            $display("FAIL tmo_before got err=%b busy=%b strt=%b want 0000 1 1", err, busy, spi_strt);
        end
        req = '0;
        tick();
        checks++;
        if ({err, gnt, spi_strt, done} !== {4'b0001, 4'b0000, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL tmo_err got err=%b gnt=%b strt=%b done=%b want 0001 0000 0 0000", err, gnt, spi_strt, done);
        end
        tick();
        checks++;
        if ({err, busy} !== 5'd0) begin errors++; $display("FAIL tmo_idle got err=%b busy=%b want 0", err, busy); end
        req = 4'b0011;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL tmo_rr_advance got %b want 0010", gnt); end
`else
        for (int i = 0; i < 1000; i++) tick();
        checks++;
        if ({busy, spi_strt, gnt, err} !== {2'b11, 4'b0001, 4'b0000}) begin
            errors++;
            $display("FAIL notmo_wait got busy=%b strt=%b gnt=%b err=%b want 1 1 0001 0000", busy, spi_strt, gnt, err);
        end
`endif
        do_reset();
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        req_data = '0;
        req_mode = '0;
        spi_cs = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_latched_data();
        test_early_drop();
        test_reset_active();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
